// File: rtl/aes_pkg.sv
// Shared AES types, field constants and tower-field basis-change matrices.
// Matrices are stored column-wise: column j is the image of input bit j.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [7:0][7:0] mat8_t;

  localparam logic [8:0] AES_POLY = 9'h11B;
  localparam byte_t SBOX_AFFINE_C = 8'h63;
  localparam byte_t SBOX_INV_AFFINE_C = 8'h05;

  // GF(2^4) = GF(2)[w]/(w^4+w+1); GF(2^8) ~ GF(2^4)[Y]/(Y^2+Y+lambda)
  localparam logic [4:0] GF16_POLY = 5'h13;
  localparam logic [3:0] GF16_LAMBDA = 4'hC;

  // Tower element t = {h,l} stands for h*Y + l with w = 0xE1, Y = 0xA2
  // in the AES field.
  localparam mat8_t TO_TOWER = {
    8'hB2, 8'h53, 8'hE2, 8'h5F,
    8'h3F, 8'h37, 8'h40, 8'h01
  };

  localparam mat8_t FROM_TOWER = {
    8'hD9, 8'h02, 8'h1A, 8'hA2,
    8'h0C, 8'h5C, 8'hE1, 8'h01
  };

  function automatic byte_t mat_mul(
    input mat8_t m,
    input byte_t v
  );
    byte_t r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (v[j]) r = r ^ m[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// Combinational GF(2^8) inverse (poly 0x11B) through GF((2^4)^2).
// Ports: a = byte to invert, z = its inverse (0 maps to 0).
module gf256_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] z
);

  function automatic logic [3:0] gf16_mul(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ (7'(x) << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'(GF16_POLY) << (i - 4));
    end
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf16_sq(
    input logic [3:0] x
  );
    return {x[3], x[1] ^ x[3], x[2], x[0] ^ x[2]};
  endfunction

  function automatic logic [3:0] gf16_sq_scl(
    input logic [3:0] x
  );
    return gf16_mul(gf16_sq(x), GF16_LAMBDA);
  endfunction

  // x^14 = x^-1 in GF(16), and 0 stays 0
  function automatic logic [3:0] gf16_inv(
    input logic [3:0] x
  );
    logic [3:0] s2, s4, s8;
    s2 = gf16_sq(x);
    s4 = gf16_sq(s2);
    s8 = gf16_sq(s4);
    return gf16_mul(gf16_mul(s2, s4), s8);
  endfunction

  byte_t t;
  logic [3:0] h, l, d, di, hi, li;

  assign t = mat_mul(TO_TOWER, a);
  assign h = t[7:4];
  assign l = t[3:0];

  // (hY+l)^-1 = (h*D^-1)Y + (h+l)*D^-1,
  // D = h^2*lambda + h*l + l^2
  assign d = gf16_sq_scl(h) ^ gf16_mul(h, l) ^ gf16_sq(l);
  assign di = gf16_inv(d);
  assign hi = gf16_mul(h, di);
  assign li = gf16_mul(h ^ l, di);

  assign z = mat_mul(FROM_TOWER, {hi, li});

endmodule

// File: rtl/sub_bytes.sv
// AES byte substitution, forward or inverse S-box, registered output.
// Ports: clk, rst_n (sync, low), a (byte in), mode (1=fwd, 0=inv), z (byte out).
// Macro SUB_BYTES_INV_EN enables the inverse direction; otherwise fwd only.
module sub_bytes
  import aes_pkg::*;
#(
  parameter byte_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       mode,
  output logic [7:0] z
);

  function automatic byte_t affine(
    input byte_t b
  );
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ SBOX_AFFINE_C;
  endfunction

  byte_t pre;
  byte_t inv;
  byte_t nxt;

`ifdef SUB_BYTES_INV_EN
  function automatic byte_t inv_affine(
    input byte_t b
  );
    return {b[1:0], b[7:2]}
      ^ {b[4:0], b[7:5]}
      ^ {b[6:0], b[7]}
      ^ SBOX_INV_AFFINE_C;
  endfunction

  assign pre = mode ? a : inv_affine(a);
  assign nxt = mode ? affine(inv) : inv;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign pre = a;
  assign nxt = affine(inv);
`endif

  gf256_inv u_inv (
    .a (pre),
    .z (inv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) z <= RST_VAL;
    else z <= nxt;
  end

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes against a field-arithmetic S-box model.
// Covers reset, spot values, exhaustive sweeps, mode toggling and random traffic.
module tb_sub_bytes;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic [7:0] a;
  logic [7:0] z;

  sub_bytes dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .mode  (mode),
    .z     (z)
  );

  always #5 clk = ~clk;

`ifdef SUB_BYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [7:0] fo [256];
  bit seen [256];

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = s[7] ? ((s << 1) ^ 8'h1B) : (s << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] faff(input logic [7:0] b);
    logic [7:0] r;
    r = b ^ 8'h63;
    for (int k = 1; k <= 4; k++) r = r ^ rotl(b, k);
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] x, input logic m);
    return (INV_EN && !m) ? isbox[x] : sbox[x];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fwd_in [5] = '{8'h00, 8'h01, 8'h53, 8'h95, 8'hFF};
  logic [7:0] fwd_ex [5] = '{8'h63, 8'h7C, 8'hED, 8'h2A, 8'h16};
  logic [7:0] inv_in [6] = '{8'h63, 8'h7C, 8'hED, 8'h2A, 8'h16, 8'h00};
  logic [7:0] inv_ex [6] = '{8'h00, 8'h01, 8'h53, 8'h95, 8'hFF, 8'h52};

  initial begin
    logic [7:0] prev;
    logic [7:0] e;
    logic r, m;
    int distinct;

    rst_n = 1'b0;
    mode = 1'b1;
    a = 8'hFF;

    for (int x = 0; x < 256; x++) begin
      e = faff(ginv(8'(x)));
      sbox[x] = e;
      isbox[e] = 8'(x);
    end

    tick;
    chk("rst_edge1", z, 8'h00);
    tick;
    chk("rst_edge2", z, 8'h00);

    rst_n = 1'b1;
    prev = 8'h00;
    for (int i = 0; i < 5; i++) begin
      a = fwd_in[i];
      #1;
      chk("fwd_lag", z, prev);
      tick;
      chk("fwd_spot", z, fwd_ex[i]);
      prev = fwd_ex[i];
    end

    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = inv_in[i];
      #1;
      chk("inv_lag", z, prev);
      tick;
      e = INV_EN ? inv_ex[i] : sbox[inv_in[i]];
      chk("inv_spot", z, e);
      prev = e;
    end

    mode = 1'b1;
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    for (int x = 0; x < 256; x++) begin
      a = 8'(x);
      tick;
      chk("fwd_sweep", z, sbox[x]);
      fo[x] = z;
      if (!seen[z]) distinct++;
      seen[z] = 1'b1;
    end
    chk_int("fwd_bijective", distinct, 256);

    mode = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    for (int x = 0; x < 256; x++) begin
      a = 8'(x);
      tick;
      chk("inv_sweep", z, model(8'(x), 1'b0));
      if (!seen[z]) distinct++;
      seen[z] = 1'b1;
    end
    chk_int("inv_bijective", distinct, 256);

`ifdef SUB_BYTES_INV_EN
    for (int x = 0; x < 256; x++) begin
      a = fo[x];
      tick;
      chk("round_trip", z, 8'(x));
    end
`endif

    a = 8'h53;
    for (int i = 0; i < 10; i++) begin
      m = (i % 2 == 0);
      r = (i != 5);
      mode = m;
      rst_n = r;
      tick;
      e = r ? model(8'h53, m) : 8'h00;
      chk("toggle", z, e);
    end
    rst_n = 1'b1;

`ifndef SUB_BYTES_INV_EN
    mode = 1'b0;
    a = 8'h53;
    tick;
    chk("mode_ignored", z, 8'hED);
`endif

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      m = 1'($urandom);
      e = 8'($urandom);
      rst_n = r;
      mode = m;
      a = e;
      tick;
      chk("random", z, r ? model(e, m) : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes.md
Name: sub_bytes

Overview:
- Low-area AES byte substitution unit: one byte in, one byte out.
- Computes the forward S-box (encrypt) or inverse S-box (decrypt), selected by `mode`.
- Both directions share a single GF(2^8) multiplicative inverter.
- The output is registered. The AES datapath instantiates it once and time-multiplexes it across state bytes and the key schedule.

Parameters:
- RST_VAL, 8'h00, value loaded into z while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- a  input  8  input byte.
- mode  input  1  1 = forward S-box (encrypt), 0 = inverse S-box (decrypt).
- z  output  8  substituted byte, registered.

Behaviour:
- Field: GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Inverse of 0x00 is defined as 0x00.
- Forward path (mode=1): z = Affine(Inv(a)).
  - Affine: b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, indices mod 8, c = 0x63.
- Inverse path (mode=0): z = Inv(InvAffine(a)).
  - InvAffine: b'_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i, d = 0x05.
- Exactly one inverter instance. The pre-inverter mux selects a (mode=1) or InvAffine(a) (mode=0). The post-inverter mux selects Affine(inv) (mode=1) or inv (mode=0).
- Inverter implemented in composite field GF((2^4)^2) (tower field, Canright-style), with 8x8 basis-change matrices at its input and output. A 256-entry LUT is not allowed.
- Timing: on each rising clk edge with rst_n=1, z <= f(a, mode). Latency 1 cycle. Throughput 1 byte/cycle.
- No handshake. a and mode are sampled every cycle.
- Reset: on a rising edge with rst_n=0, z <= RST_VAL. Reset takes priority over the input. Reset asserted mid-stream discards the in-flight result.
- A mode change takes effect on the next edge. There is no internal state other than z.
- X-free: all 256 values of a, for both modes, produce defined outputs.

Optional Feature:
- Macro SUB_BYTES_INV_EN.
- Defined: full behaviour above; mode selects the direction.
- Undefined:
  - Inverse-affine and both muxes are removed.
  - mode is ignored, port kept for interface compatibility.
  - z always gets the forward S-box value.
  - Used for encrypt-only, minimum-area builds.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_POLY (9'h11B), SBOX_AFFINE_C (8'h63), SBOX_INV_AFFINE_C (8'h05);
  - the basis-change matrix constants;
  - typedef byte_t (logic [7:0]).
- One sub-module, gf256_inv:
  - purely combinational composite-field inverter, 8-bit in/out;
  - contains GF(2^4) multiply, square-scale and inverse as functions.
- sub_bytes holds the affine/inverse-affine logic, the muxes and the output register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with a=8'hFF -> z=8'h00. Release reset -> z valid one edge later.
- Forward spot checks, mode=1: a=00->63, 01->7C, 53->ED, 95->2A, FF->16, each appearing on z exactly 1 cycle after a is applied.
- Inverse spot checks, mode=0: a=63->00, 7C->01, ED->53, 2A->95, 16->FF, 00->52.
- Exhaustive: sweep a=0..255 in both modes.
  - Compare against a behavioural S-box model.
  - Check that InvS(S(x))=x for all x.
  - Check that both directions are bijective (256 distinct outputs each).
- Mode toggling every cycle with a=53: z alternates ED (mode=1) and 50 (mode=0), each with 1-cycle lag. Assert rst_n=0 mid-sequence -> z=00 on that edge.
- With SUB_BYTES_INV_EN undefined: mode=0, a=53 -> z=ED (mode ignored).
